spi_slave_regfile: RTL and testbench

//  Synthesizable SPI slave with a 2**AW x DW register file, clocked from the system clock.

---
 rtl/spi_slave_regfile.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI slave in front of a 2**AW x DW register file, all logic on wb_clk_i.
// The first word of a frame is a command (bit DW-1 = read, bits AW-1:0 = start address);
// the following words are written to, or read from, consecutive addresses (wrapping).
// A host port gives the local side direct write access and registered read access.
// Optional feature macro: SPI_SLAVE_IRQ_EN adds a write-frame interrupt flop on irq_o.
module spi_slave_regfile #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 3,
    parameter bit          CPOL = 1'b0,
    parameter bit          CPHA = 1'b0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          csn_i,
    input  logic          sck_i,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          miso_oe_o,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_adr_i,
    input  logic [DW-1:0] host_dat_i,
    output logic [DW-1:0] host_dat_o,
    output logic          frame_done_o,
    output logic          irq_o,
    input  logic          irq_ack_i
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = $clog2(DW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;

    logic [1:0]    csn_sync;
    logic [1:0]    sck_sync;
    logic [1:0]    mosi_sync;
    logic          csn_prev;
    logic          sck_prev;

    logic [DW-2:0] sri;
    logic [DW-1:0] sro;
    logic [CW-1:0] cnt;
    logic [AW-1:0] ptr;
    logic          rnw;
    logic          seen;

    logic [DW-1:0] mem [DEPTH];

    logic          csn_s_c;
    logic          sck_s_c;
    logic          mosi_s_c;
    logic          csn_fall_c;
    logic          csn_rise_c;
    logic          sck_edge_c;
    logic          lead_c;
    logic          trail_c;
    logic          sample_c;
    logic          shift_c;
    logic          active_c;
    logic          sample_act_c;
    logic          word_done_c;
    logic          frame_end_c;
    logic          spi_we_c;
    logic [DW-1:0] word_c;

    // Two-flop synchronisers plus previous-level registers for edge detection.
    // csn resets low so a frame already in progress at reset release is ignored
    // until csn has been seen high and then low again.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csn_sync  <= 2'b00;
            csn_prev  <= 1'b0;
            sck_sync  <= {2{CPOL}};
            sck_prev  <= CPOL;
            mosi_sync <= 2'b00;
        end else begin
            csn_sync  <= {csn_sync[0], csn_i};
            csn_prev  <= csn_sync[1];
            sck_sync  <= {sck_sync[0], sck_i};
            sck_prev  <= sck_sync[1];
            mosi_sync <= {mosi_sync[0], mosi_i};
        end
    end

    // Edge decode on the synchronised levels.
    always_comb begin
        csn_s_c      = csn_sync[1];
        sck_s_c      = sck_sync[1];
        mosi_s_c     = mosi_sync[1];
        csn_fall_c   = csn_prev & ~csn_s_c;
        csn_rise_c   = ~csn_prev & csn_s_c;
        sck_edge_c   = sck_s_c ^ sck_prev;
        lead_c       = sck_edge_c & (sck_s_c != CPOL);
        trail_c      = sck_edge_c & (sck_s_c == CPOL);
        sample_c     = CPHA ? trail_c : lead_c;
        shift_c      = CPHA ? lead_c : trail_c;
        active_c     = (state != IDLE) & ~csn_rise_c;
        sample_act_c = sample_c & active_c;
        word_done_c  = sample_act_c & (cnt == '0);
        frame_end_c  = csn_rise_c & (state != IDLE);
        spi_we_c     = word_done_c & (state == DATA) & ~rnw;
        word_c       = {sri, mosi_s_c};
    end

    // Frame state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame state transitions: select, command word, data words, deselect.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (csn_fall_c) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (csn_rise_c) begin
                    state_next = IDLE;
                end else if (word_done_c) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (csn_rise_c) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial datapath: shift-in, bit counter, address pointer, shift-out and miso drive.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sri          <= '0;
            sro          <= '0;
            cnt          <= CW'(DW - 1);
            ptr          <= '0;
            rnw          <= 1'b0;
            seen         <= 1'b0;
            miso_o       <= 1'b0;
            miso_oe_o    <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;

            if (state == IDLE) begin
                cnt       <= CW'(DW - 1);
                rnw       <= 1'b0;
                seen      <= 1'b0;
                miso_o    <= 1'b0;
                miso_oe_o <= 1'b0;
            end

            // Deselect: partial word dropped, line released in the same cycle.
            if (frame_end_c) begin
                frame_done_o <= seen;
                miso_o       <= 1'b0;
                miso_oe_o    <= 1'b0;
            end

            if (sample_act_c) begin
                sri <= word_c[DW-2:0];
                cnt <= (cnt == '0) ? CW'(DW - 1) : cnt - CW'(1);
            end

            // Command word complete: latch direction and start address; preload for reads.
            if (word_done_c && (state == CMD)) begin
                rnw <= word_c[DW-1];
                if (word_c[DW-1]) begin
                    sro       <= mem[word_c[AW-1:0]];
                    ptr       <= word_c[AW-1:0] + AW'(1);
                    miso_oe_o <= 1'b1;
                end else begin
                    ptr <= word_c[AW-1:0];
                end
            end

            // Data word complete: advance pointer; reads preload the next word.
            if (word_done_c && (state == DATA)) begin
                seen <= 1'b1;
                ptr  <= ptr + AW'(1);
                if (rnw) begin
                    sro <= mem[ptr];
                end
            end

            if (shift_c && active_c && (state == DATA) && rnw) begin
                miso_o <= sro[DW-1];
                sro    <= {sro[DW-2:0], 1'b0};
            end
        end
    end

    // Register file: host write first so a same-address SPI write takes precedence.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (host_we_i) begin
                mem[host_adr_i] <= host_dat_i;
            end
            if (spi_we_c) begin
                mem[ptr] <= word_c;
            end
        end
    end

    // Host read port, one cycle latency.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            host_dat_o <= '0;
        end else begin
            host_dat_o <= mem[host_adr_i];
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_q;

    // Write-frame interrupt: set with frame_done on write frames, set beats ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_q <= 1'b0;
        end else if (frame_end_c && seen && !rnw) begin
            irq_q <= 1'b1;
        end else if (irq_ack_i) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = irq_ack_i;
    assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: scoreboard bench for spi_slave_regfile.
// dut0 runs SPI mode 0, dut3 runs SPI mode 3; both DW=8, AW=3.
module tb_spi_slave_regfile;

    localparam int H = 5;

    typedef struct {
        int         d;
        logic [7:0] exp;
        string      name;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       csn [2];
    logic       sck [2];
    logic       mosi = 1'b0;
    logic       miso [2];
    logic       oe [2];
    logic       host_we [2];
    logic [2:0] host_adr [2];
    logic [7:0] host_din [2];
    logic [7:0] host_dout [2];
    logic       fd [2];
    logic       irq [2];
    logic       ack [2];

    int         checks = 0;
    int         errors = 0;
    int         fd_cnt [2];
    int         exp_fd [2];
    item_t      q_miso [$];
    item_t      q_host [$];
    logic [1:0] rd_req = 2'b00;
    logic [1:0] rd_vld = 2'b00;

    always #5 clk = ~clk;

    spi_slave_regfile #(.DW(8), .AW(3), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .csn_i(csn[0]), .sck_i(sck[0]), .mosi_i(mosi),
        .miso_o(miso[0]), .miso_oe_o(oe[0]), .host_we_i(host_we[0]), .host_adr_i(host_adr[0]),
        .host_dat_i(host_din[0]), .host_dat_o(host_dout[0]), .frame_done_o(fd[0]),
        .irq_o(irq[0]), .irq_ack_i(ack[0])
    );

    spi_slave_regfile #(.DW(8), .AW(3), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .csn_i(csn[1]), .sck_i(sck[1]), .mosi_i(mosi),
        .miso_o(miso[1]), .miso_oe_o(oe[1]), .host_we_i(host_we[1]), .host_adr_i(host_adr[1]),
        .host_dat_i(host_din[1]), .host_dat_o(host_dout[1]), .frame_done_o(fd[1]),
        .irq_o(irq[1]), .irq_ack_i(ack[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-done pulse counter (one count per high cycle).
    always @(negedge clk) begin
        if (fd[0] === 1'b1) fd_cnt[0]++;
        if (fd[1] === 1'b1) fd_cnt[1]++;
    end

    // Host read monitor: data is due one cycle after the address was presented.
    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        item_t it;
        if (rd_vld != 2'b00) begin
            if (q_host.size() == 0) begin
                check("host_queue_underflow", 32'd1, 32'd0);
            end else begin
                it = q_host.pop_front();
                check(it.name, 32'(host_dout[it.d]), 32'(it.exp));
            end
        end
    end

    // SPI line monitors: both modes sample on rising sck. The command is decoded from
    // mosi; write frames must keep miso/oe low, read frames deliver queued bytes.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int         nb  = 0;
        logic       rnw = 1'b0;
        logic [7:0] rx  = 8'h00;
        logic [7:0] cmd = 8'h00;
        always @(posedge sck[g] or posedge csn[g]) begin
            item_t it;
            if (csn[g] === 1'b1) begin
                nb = 0;
            end else if (csn[g] === 1'b0) begin
                rx  = {rx[6:0], miso[g]};
                cmd = {cmd[6:0], mosi};
                nb++;
                if (nb == 8) rnw = cmd[7];
                if (nb > 8) begin
                    check($sformatf("miso_oe_dut%0d_bit%0d", g, nb), 32'(oe[g]), 32'(rnw));
                    if (!rnw) begin
                        check($sformatf("miso_idle_dut%0d_bit%0d", g, nb), 32'(miso[g]), 32'd0);
                    end else if ((nb % 8) == 0) begin
                        if (q_miso.size() == 0) begin
                            check("miso_queue_underflow", 32'd1, 32'd0);
                        end else begin
                            it = q_miso.pop_front();
                            check(it.name, 32'(rx), 32'(it.exp));
                        end
                    end
                end
            end
        end
    end

    // SPI master: nbits taken MSB first from data; d=0 mode 0, d=1 mode 3.
    task automatic spi_frame(input int d, input int nbits, input logic [23:0] data);
        logic cp;
        logic [23:0] sh;
        cp = (d == 1);
        sh = data;
        csn[d] = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (!cp) begin
                mosi = sh[23];
                repeat (H) @(negedge clk);
                sck[d] = 1'b1;
                repeat (H) @(negedge clk);
                sck[d] = 1'b0;
            end else begin
                sck[d] = 1'b0;
                mosi = sh[23];
                repeat (H) @(negedge clk);
                sck[d] = 1'b1;
                repeat (H) @(negedge clk);
            end
            sh = sh << 1;
        end
        repeat (H) @(negedge clk);
        csn[d] = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic host_read(input int d, input logic [2:0] a, input logic [7:0] e, input string nm);
        host_adr[d] = a;
        q_host.push_back('{d, e, nm});
        rd_req[d] = 1'b1;
        @(negedge clk);
        rd_req[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_rd(input int d, input logic [7:0] e, input string nm);
        q_miso.push_back('{d, e, nm});
    endtask

    task automatic check_fd(input int d, input string nm);
        check(nm, 32'(fd_cnt[d]), 32'(exp_fd[d]));
    endtask

    task automatic pulse_ack(input int d);
        ack[d] = 1'b1;
        @(negedge clk);
        ack[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            csn[d] = 1'b1; sck[d] = (d == 1); host_we[d] = 1'b0; host_adr[d] = 3'd0;
            host_din[d] = 8'h00; ack[d] = 1'b0; fd_cnt[d] = 0; exp_fd[d] = 0;
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_miso_%0d", d), 32'(miso[d]), 32'd0);
            check($sformatf("rst_oe_%0d", d), 32'(oe[d]), 32'd0);
            check($sformatf("rst_hostdat_%0d", d), 32'(host_dout[d]), 32'd0);
            check($sformatf("rst_fd_%0d", d), 32'(fd[d]), 32'd0);
            check($sformatf("rst_irq_%0d", d), 32'(irq[d]), 32'd0);
        end
        host_read(0, 3'd5, 8'h00, "rst_mem5");
        repeat (5) @(negedge clk);

        // Mode 0 write frame: cmd 02, A5 5A
        spi_frame(0, 24, {8'h02, 8'hA5, 8'h5A});
        exp_fd[0] = 1;
        check_fd(0, "m0_wr_frame_done");
        host_read(0, 3'd2, 8'hA5, "m0_wr_mem2");
        host_read(0, 3'd3, 8'h5A, "m0_wr_mem3");
`ifdef SPI_SLAVE_IRQ_EN
        check("irq_after_write", 32'(irq[0]), 32'd1);
        pulse_ack(0);
        check("irq_after_ack", 32'(irq[0]), 32'd0);
`else
        check("irq_tied_low", 32'(irq[0]), 32'd0);
`endif

        // Mode 0 read frame: cmd 82 -> A5 5A
        expect_rd(0, 8'hA5, "m0_rd_byte0");
        expect_rd(0, 8'h5A, "m0_rd_byte1");
        spi_frame(0, 24, {8'h82, 8'hA5, 8'h5A});
        exp_fd[0] = 2;
        check_fd(0, "m0_rd_frame_done");
        check("m0_rd_oe_after", 32'(oe[0]), 32'd0);
        check("irq_after_read", 32'(irq[0]), 32'd0);

        // Address wrap: cmd 07, 11 22
        spi_frame(0, 24, {8'h07, 8'h11, 8'h22});
        exp_fd[0] = 3;
        check_fd(0, "wrap_frame_done");
        host_read(0, 3'd7, 8'h11, "wrap_mem7");
        host_read(0, 3'd0, 8'h22, "wrap_mem0");
`ifdef SPI_SLAVE_IRQ_EN
        pulse_ack(0);
`endif

        // Read across the wrap: cmd 87 -> 11 22
        expect_rd(0, 8'h11, "wrap_rd_byte0");
        expect_rd(0, 8'h22, "wrap_rd_byte1");
        spi_frame(0, 24, {8'h87, 8'h11, 8'h22});
        exp_fd[0] = 4;
        check_fd(0, "wrap_rd_frame_done");

        // Abort: cmd 01 plus 5 data bits
        spi_frame(0, 13, {8'h01, 5'b10110, 11'd0});
        check_fd(0, "abort_no_frame_done");
        check("abort_oe", 32'(oe[0]), 32'd0);
        host_read(0, 3'd1, 8'h00, "abort_mem1");

        // Collision: host writes C3 to addr 3 in the SPI write cycle of 3C to addr 3
        host_adr[0] = 3'd3;
        host_din[0] = 8'hC3;
        fork
            spi_frame(0, 16, {8'h03, 8'h3C, 8'h00});
            begin
                repeat (16) @(posedge sck[0]);
                repeat (2) @(negedge clk);
                host_we[0] = 1'b1;
                @(negedge clk);
                host_we[0] = 1'b0;
            end
        join
        exp_fd[0] = 5;
        check_fd(0, "coll_frame_done");
        host_read(0, 3'd3, 8'h3C, "coll_mem3");

        // Mode 3: write then read cmd 82 -> A5 5A
        spi_frame(1, 24, {8'h02, 8'hA5, 8'h5A});
        exp_fd[1] = 1;
        check_fd(1, "m3_wr_frame_done");
        host_read(1, 3'd2, 8'hA5, "m3_wr_mem2");
        expect_rd(1, 8'hA5, "m3_rd_byte0");
        expect_rd(1, 8'h5A, "m3_rd_byte1");
        spi_frame(1, 24, {8'h82, 8'hA5, 8'h5A});
        exp_fd[1] = 2;
        check_fd(1, "m3_rd_frame_done");

        // Mode 3 read aborted mid-word: oe drops, no frame_done
        spi_frame(1, 13, {8'h82, 5'b00000, 11'd0});
        check_fd(1, "m3_abort_no_frame_done");
        check("m3_abort_oe", 32'(oe[1]), 32'd0);
        check("m3_abort_mem2", 32'(dut3.mem[2]), 32'h0000_00A5);

        repeat (5) @(negedge clk);
        check("miso_queue_drained", 32'(q_miso.size()), 32'd0);
        check("host_queue_drained", 32'(q_host.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
